four_way_bus_arbiter: RTL

FOUR_WAY_BUS_ARBITER -- requirements
Module: four_way_bus_arbiter

---
 rtl/four_way_arb_pkg.sv | 22 ++
 rtl/rr_pick4.sv | 31 +++
 rtl/four_way_bus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/four_way_arb_pkg.sv
// Shared types and constants for the four-way bus arbiter.
`timescale 1ns/1ps
package four_way_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Expand an owner index into a one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: the first set request at or after
// ptr (modulo 4) wins.
`timescale 1ns/1ps
module rr_pick4
  import four_way_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest slot back to ptr so the nearest requester wins.
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/four_way_bus_arbiter.sv
// Four-source round-robin bus arbiter with per-owner hold limit and a
// shared 4:1 tri-state data mux.
// Build option: define ARB_TURNAROUND_EN to insert a one-cycle idle TURN
// state after every release; otherwise the next winner is granted
// back-to-back on the release edge.
// MAX_HOLD must be within 2..255 (hold_cnt is 8 bits wide).
`timescale 1ns/1ps
module four_way_bus_arbiter
  import four_way_arb_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DW-1:0]      d0,
  input  logic [DW-1:0]      d1,
  input  logic [DW-1:0]      d2,
  input  logic [DW-1:0]      d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               y_oe,
  output logic [DW-1:0]      y,
  output logic               busy
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt, sel_nxt, pick_ptr, winner;
  logic [7:0]       hold_cnt, hold_nxt;
  logic             found, release_now;
  logic [DW-1:0]    y_mux;

  // On release the picker already sees the rotated pointer, so a
  // back-to-back grant uses the same priority order as a fresh arbitration.
  assign release_now = (state == GRANT) && (!req[sel] || hold_cnt == HOLD_LAST);
  assign pick_ptr    = (state == GRANT) ? sel + SEL_W'(1) : ptr;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .winner (winner),
    .found  (found)
  );

  // Next-state, owner, pointer and hold-counter decisions.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE, TURN: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (!release_now) begin
          hold_nxt = hold_cnt + 8'd1;
        end else begin
          // Timed-out owner keeps no priority: it is only behind the
          // rotated pointer like everyone else.
          ptr_nxt  = pick_ptr;
          hold_nxt = '0;
`ifdef ARB_TURNAROUND_EN
          state_nxt = TURN;
`else
          if (found) begin
            state_nxt = GRANT;
            sel_nxt   = winner;
          end else begin
            state_nxt = IDLE;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset clears everything immediately, even mid-grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Grant is decoded from the registered owner, so it is one-hot by
  // construction and drops to zero the instant reset asserts.
  assign gnt  = (state == GRANT) ? idx_to_onehot(sel) : '0;
  assign y_oe = |gnt;
  assign busy = (state != IDLE);

  // Shared 4:1 data mux steered by the registered select.
  always_comb begin
    y_mux = d0;
    case (sel)
      2'd0:    y_mux = d0;
      2'd1:    y_mux = d1;
      2'd2:    y_mux = d2;
      default: y_mux = d3;
    endcase
  end

  assign y = y_oe ? y_mux : {DW{1'bz}};

endmodule
